ccff_stream_loader: RTL and testbench

Configuration-chain loader that feeds the `ccff_head` input of the first tile in the FPGA fabric's configuration flip-flop chain. It accepts the bitstream as a valid/ready byte stream, serializes it MSB-first onto `ccff_head` at one bit per cycle, and drives a clock-gate enable so the chain shifts only when a valid bit is present. It can optionally run a second, identical pass in which `ccff_tail`, returned from the last tile, is compared bit-for-bit against the first pass.

---
 rtl/ccff_loader_pkg.sv | 15 +
 rtl/ccff_byte_serializer.sv | 80 ++++++++
 rtl/ccff_stream_loader.sv | 141 ++++++++++++++
 tb/tb_ccff_stream_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared types and constants for the configuration-chain loader.
//   state_e   : pass sequencer states
//   ERR_CNT_W : width of the saturating verify-mismatch counter
package ccff_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_VERIFY,
      ST_DONE
   } state_e;

   localparam int unsigned ERR_CNT_W = 16;

endpackage

// File: rtl/ccff_byte_serializer.sv
// ccff_byte_serializer: one-byte holding register that turns a valid/ready byte
// stream into an MSB-first bit stream, one bit per cycle, for one pass of
// CHAIN_LEN bits. In the final byte of a pass, the unused LSBs are dropped.
//   clk, reset   : clock, synchronous active-high reset
//   clear        : forget buffered data and restart the per-pass byte count
//   active       : a pass is running (in_ready stays low otherwise)
//   in_data/in_valid/in_ready : byte stream handshake
//   nxt_vld      : a bit is held in the next cycle (that cycle is a shift cycle)
//   nxt_bit      : the bit presented in that next cycle
module ccff_byte_serializer #(
   parameter int unsigned CHAIN_LEN = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       active,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       nxt_vld,
   output logic       nxt_bit
);

   localparam int unsigned NBYTES    = (CHAIN_LEN + 7) / 8;
   localparam int unsigned BC_W      = $clog2(NBYTES + 1);
   localparam int unsigned TAIL_BITS = CHAIN_LEN % 8;
   // Index of the last bit that is actually shifted out of the final byte.
   localparam logic [2:0]  FINAL_IDX = (TAIL_BITS == 0) ? 3'd0 : 3'(8 - TAIL_BITS);

   logic [7:0]      hold_q, hold_d;
   logic [2:0]      idx_q, idx_d;
   logic            vld_q, vld_d;
   logic [BC_W-1:0] nbytes_q, nbytes_d;
   logic            final_byte;
   logic            last_bit;

   always_comb begin
      hold_d   = hold_q;
      idx_d    = idx_q;
      vld_d    = vld_q;
      nbytes_d = nbytes_q;

      // Once the last byte of the pass has been taken, the held byte is the final one.
      final_byte = (nbytes_q == BC_W'(NBYTES));
      last_bit   = vld_q && (idx_q == (final_byte ? FINAL_IDX : 3'd0));
      in_ready   = active && (!vld_q || last_bit) && !final_byte;

      if (clear) begin
         vld_d    = 1'b0;
         nbytes_d = '0;
      end else if (in_ready && in_valid) begin
         hold_d   = in_data;
         idx_d    = 3'd7;
         vld_d    = 1'b1;
         nbytes_d = nbytes_q + BC_W'(1);
      end else if (last_bit) begin
         vld_d = 1'b0;
      end else if (vld_q) begin
         idx_d = idx_q - 3'd1;
      end

      nxt_vld = vld_d;
      nxt_bit = hold_d[idx_d];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q   <= '0;
         idx_q    <= '0;
         vld_q    <= 1'b0;
         nbytes_q <= '0;
      end else begin
         hold_q   <= hold_d;
         idx_q    <= idx_d;
         vld_q    <= vld_d;
         nbytes_q <= nbytes_d;
      end
   end

endmodule

// File: rtl/ccff_stream_loader.sv
// ccff_stream_loader: feeds the head of the FPGA configuration flip-flop chain
// from a byte stream, with an optional verify pass that compares the chain's
// tail against a resent copy of the bitstream.
//   prog_clk, prog_reset : configuration clock, synchronous active-high reset
//   start, verify        : begin a load (verify sampled with start)
//   in_data/in_valid/in_ready : bitstream byte handshake
//   ccff_head, chain_clk_en   : registered serial data and chain clock enable
//   ccff_tail            : serial data returned from the last tile
//   busy, done           : pass in progress / final pass completed (level)
//   error, err_count     : sticky verify mismatch flag and saturating count
module ccff_stream_loader
   import ccff_loader_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = 1024,
   parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                 prog_clk,
   input  logic                 prog_reset,
   input  logic                 start,
   input  logic                 verify,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 ccff_head,
   output logic                 chain_clk_en,
   input  logic                 ccff_tail,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [ERR_CNT_W-1:0] err_count
);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 verify_q, verify_d;
   logic                 head_q, head_d;
   logic                 clk_en_q, clk_en_d;
   logic                 error_q, error_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   logic start_take;
   logic pass_end;
   logic ser_active;
   logic ser_clear;
   logic ser_nxt_vld;
   logic ser_nxt_bit;

   ccff_byte_serializer #(
      .CHAIN_LEN (CHAIN_LEN)
   ) u_ser (
      .clk      (prog_clk),
      .reset    (prog_reset),
      .clear    (ser_clear),
      .active   (ser_active),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .nxt_vld  (ser_nxt_vld),
      .nxt_bit  (ser_nxt_bit)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      verify_d  = verify_q;
      error_d   = error_q;
      err_cnt_d = err_cnt_q;

      start_take = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      // clk_en_q mirrors "buffer holds a bit" in this cycle, so it marks the shift cycle.
      pass_end   = clk_en_q && (cnt_q == CNT_W'(CHAIN_LEN - 1));
      ser_active = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
      ser_clear  = start_take || pass_end;

      // The serializer's next-cycle view is registered here so head and enable
      // are flop outputs yet still coincide with the bit the buffer holds.
      clk_en_d = ser_nxt_vld;
      head_d   = ser_nxt_vld ? ser_nxt_bit : head_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_take) begin
               state_d   = ST_LOAD;
               cnt_d     = '0;
               verify_d  = verify;
               error_d   = 1'b0;
               err_cnt_d = '0;
            end
         end
         ST_LOAD: begin
            if (pass_end) begin
               cnt_d   = '0;
               state_d = verify_q ? ST_VERIFY : ST_DONE;
            end else if (clk_en_q) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_VERIFY: begin
            if (clk_en_q && (ccff_tail != head_q)) begin
               error_d = 1'b1;
               if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
            if (pass_end) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else if (clk_en_q) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         verify_q  <= 1'b0;
         head_q    <= 1'b0;
         clk_en_q  <= 1'b0;
         error_q   <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         verify_q  <= verify_d;
         head_q    <= head_d;
         clk_en_q  <= clk_en_d;
         error_q   <= error_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign ccff_head    = head_q;
   assign chain_clk_en = clk_en_q;
   assign busy         = (state_q == ST_LOAD) || (state_q == ST_VERIFY);
   assign done         = (state_q == ST_DONE);
   assign error        = error_q;
   assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_ccff_stream_loader.sv
// Bench for ccff_stream_loader: three instances (CHAIN_LEN 8, 10, 16), each
// with a behavioural shift-register chain model driving ccff_tail.
module tb_ccff_stream_loader;

   logic        clk;
   logic        rst;
   logic        start     [3];
   logic        verify    [3];
   logic        in_valid  [3];
   logic [7:0]  in_data   [3];
   logic        tail      [3];
   logic        flip      [3];
   logic        in_ready  [3];
   logic        head      [3];
   logic        cen       [3];
   logic        busy      [3];
   logic        done      [3];
   logic        error     [3];
   logic [15:0] err_count [3];

   logic [7:0]  ch8  = '0;
   logic [9:0]  ch10 = '0;
   logic [15:0] ch16 = '0;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  stim [$];
   int          r_shifts, r_first, r_last, r_gaps, r_done, r_bytes;
   logic        r_done_busy;
   logic [31:0] r_heads;

   ccff_stream_loader #(.CHAIN_LEN(8)) u8 (
      .prog_clk(clk), .prog_reset(rst), .start(start[0]), .verify(verify[0]),
      .in_data(in_data[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .ccff_head(head[0]), .chain_clk_en(cen[0]), .ccff_tail(tail[0]),
      .busy(busy[0]), .done(done[0]), .error(error[0]), .err_count(err_count[0])
   );

   ccff_stream_loader #(.CHAIN_LEN(10)) u10 (
      .prog_clk(clk), .prog_reset(rst), .start(start[1]), .verify(verify[1]),
      .in_data(in_data[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .ccff_head(head[1]), .chain_clk_en(cen[1]), .ccff_tail(tail[1]),
      .busy(busy[1]), .done(done[1]), .error(error[1]), .err_count(err_count[1])
   );

   ccff_stream_loader #(.CHAIN_LEN(16)) u16 (
      .prog_clk(clk), .prog_reset(rst), .start(start[2]), .verify(verify[2]),
      .in_data(in_data[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .ccff_head(head[2]), .chain_clk_en(cen[2]), .ccff_tail(tail[2]),
      .busy(busy[2]), .done(done[2]), .error(error[2]), .err_count(err_count[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Chain models: first bit shifted lands at the MSB (tail end).
   always @(posedge clk) begin
      if (cen[0]) ch8  <= {ch8[6:0],  head[0]};
      if (cen[1]) ch10 <= {ch10[8:0], head[1]};
      if (cen[2]) ch16 <= {ch16[14:0], head[2]};
   end

   always_comb begin
      tail[0] = ch8[7]   ^ flip[0];
      tail[1] = ch10[9]  ^ flip[1];
      tail[2] = ch16[15] ^ flip[2];
   end

   // Drives one transaction on instance d from stim[], recording shift activity.
   // Called at a negedge; returns at the negedge where done is seen (or after abort).
   task automatic run(input int d, input logic vfy, input int stall_at, input int stall_len,
                      input int fa, input int fb, input int abort_at, input int restart_at);
      int   bi        = 0;
      int   stall_rem = stall_len;
      logic acc       = 1'b0;
      logic restarted = 1'b0;
      r_shifts = 0; r_first = -1; r_last = -1; r_gaps = 0; r_done = -1;
      r_done_busy = 1'b1; r_heads = '0;
      start[d] = 1'b1; verify[d] = vfy; in_valid[d] = 1'b0;
      for (int c = 1; c <= 150; c++) begin
         @(negedge clk);
         start[d] = 1'b0;
         if (acc) bi++;
         acc = 1'b0;
         if (cen[d]) begin
            flip[d] = (r_shifts == fa) || (r_shifts == fb);
            r_heads = {r_heads[30:0], head[d]};
            if (r_first < 0) r_first = c;
            r_last = c;
            r_shifts++;
         end else begin
            flip[d] = 1'b0;
            if (r_first >= 0 && busy[d]) r_gaps++;
         end
         if (done[d]) begin
            r_done = c;
            r_done_busy = busy[d];
            break;
         end
         if (abort_at >= 0 && r_shifts == abort_at) begin
            rst = 1'b1; in_valid[d] = 1'b0; flip[d] = 1'b0;
            @(negedge clk);
            break;
         end
         if (restart_at >= 0 && r_shifts == restart_at && !restarted) begin
            start[d] = 1'b1;
            restarted = 1'b1;
         end
         if (bi < stim.size()) begin
            in_data[d] = stim[bi];
            if (in_ready[d] && bi == stall_at && stall_rem > 0) begin
               in_valid[d] = 1'b0;
               stall_rem--;
            end else begin
               in_valid[d] = 1'b1;
            end
         end else begin
            in_valid[d] = 1'b0;
         end
         acc = in_valid[d] && in_ready[d];
      end
      in_valid[d] = 1'b0; flip[d] = 1'b0; start[d] = 1'b0;
      r_bytes = bi;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({in_ready[i], head[i], cen[i], busy[i], done[i], error[i], err_count[i]} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_outputs inst=%0d actual=%b required=0", i,
                     {in_ready[i], head[i], cen[i], busy[i], done[i], error[i], err_count[i]});
         end
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_byte();
      stim.delete(); stim.push_back(8'hA5);
      run(0, 1'b0, -1, 0, -1, -1, -1, -1);
      n_cmp++; if (r_shifts !== 8) begin n_bad++; $display("FAIL single_shifts actual=%0d required=8", r_shifts); end
      n_cmp++; if (r_heads[7:0] !== 8'hA5) begin n_bad++; $display("FAIL single_heads actual=%h required=a5", r_heads[7:0]); end
      n_cmp++; if (r_first !== 2) begin n_bad++; $display("FAIL single_latency actual=%0d required=2", r_first); end
      n_cmp++; if (r_gaps !== 0) begin n_bad++; $display("FAIL single_gaps actual=%0d required=0", r_gaps); end
      n_cmp++; if (r_done !== r_last + 1) begin n_bad++; $display("FAIL single_done_cycle actual=%0d required=%0d", r_done, r_last + 1); end
      n_cmp++; if (r_done_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_at_done actual=%b required=0", r_done_busy); end
      n_cmp++; if (error[0] !== 1'b0) begin n_bad++; $display("FAIL single_error actual=%b required=0", error[0]); end
      n_cmp++; if (ch8 !== 8'hA5) begin n_bad++; $display("FAIL single_chain actual=%h required=a5", ch8); end
   endtask

   task automatic test_verify_clean();
      stim.delete(); stim.push_back(8'h3C); stim.push_back(8'h3C);
      run(0, 1'b1, -1, 0, -1, -1, -1, -1);
      n_cmp++; if (r_shifts !== 16) begin n_bad++; $display("FAIL vclean_shifts actual=%0d required=16", r_shifts); end
      n_cmp++; if (r_heads[15:0] !== 16'h3C3C) begin n_bad++; $display("FAIL vclean_heads actual=%h required=3c3c", r_heads[15:0]); end
      n_cmp++; if (r_gaps !== 1) begin n_bad++; $display("FAIL vclean_pass_gap actual=%0d required=1", r_gaps); end
      n_cmp++; if (r_done !== r_last + 1) begin n_bad++; $display("FAIL vclean_done_cycle actual=%0d required=%0d", r_done, r_last + 1); end
      n_cmp++; if (error[0] !== 1'b0) begin n_bad++; $display("FAIL vclean_error actual=%b required=0", error[0]); end
      n_cmp++; if (err_count[0] !== 16'd0) begin n_bad++; $display("FAIL vclean_err_count actual=%0d required=0", err_count[0]); end
      n_cmp++; if (ch8 !== 8'h3C) begin n_bad++; $display("FAIL vclean_chain actual=%h required=3c", ch8); end
   endtask

   task automatic test_verify_faults();
      stim.delete(); stim.push_back(8'h3C); stim.push_back(8'h3C);
      run(0, 1'b1, -1, 0, 9, 14, -1, -1);
      n_cmp++; if (r_shifts !== 16) begin n_bad++; $display("FAIL vfault_shifts actual=%0d required=16", r_shifts); end
      n_cmp++; if (done[0] !== 1'b1) begin n_bad++; $display("FAIL vfault_done actual=%b required=1", done[0]); end
      n_cmp++; if (error[0] !== 1'b1) begin n_bad++; $display("FAIL vfault_error actual=%b required=1", error[0]); end
      n_cmp++; if (err_count[0] !== 16'd2) begin n_bad++; $display("FAIL vfault_err_count actual=%0d required=2", err_count[0]); end
   endtask

   task automatic test_partial_byte();
      stim.delete(); stim.push_back(8'hFF); stim.push_back(8'hC0);
      run(1, 1'b0, -1, 0, -1, -1, -1, -1);
      n_cmp++; if (r_shifts !== 10) begin n_bad++; $display("FAIL partial_shifts actual=%0d required=10", r_shifts); end
      n_cmp++; if (r_heads[9:0] !== 10'h3FF) begin n_bad++; $display("FAIL partial_heads actual=%h required=3ff", r_heads[9:0]); end
      n_cmp++; if (r_bytes !== 2) begin n_bad++; $display("FAIL partial_bytes actual=%0d required=2", r_bytes); end
      n_cmp++; if (r_done !== 12) begin n_bad++; $display("FAIL partial_done_cycle actual=%0d required=12", r_done); end
      n_cmp++; if (ch10 !== 10'h3FF) begin n_bad++; $display("FAIL partial_chain actual=%h required=3ff", ch10); end
   endtask

   task automatic test_stall();
      stim.delete(); stim.push_back(8'h5A); stim.push_back(8'hC3);
      run(2, 1'b0, 1, 3, -1, -1, -1, -1);
      n_cmp++; if (r_shifts !== 16) begin n_bad++; $display("FAIL stall_shifts actual=%0d required=16", r_shifts); end
      n_cmp++; if (r_heads[15:0] !== 16'h5AC3) begin n_bad++; $display("FAIL stall_heads actual=%h required=5ac3", r_heads[15:0]); end
      n_cmp++; if (r_gaps !== 3) begin n_bad++; $display("FAIL stall_gap actual=%0d required=3", r_gaps); end
      n_cmp++; if (r_done !== 21) begin n_bad++; $display("FAIL stall_done_cycle actual=%0d required=21", r_done); end
      n_cmp++; if (ch16 !== 16'h5AC3) begin n_bad++; $display("FAIL stall_chain actual=%h required=5ac3", ch16); end
   endtask

   task automatic test_reset_and_restart();
      stim.delete(); stim.push_back(8'h12); stim.push_back(8'h34);
      run(2, 1'b0, -1, 0, -1, -1, 4, -1);
      n_cmp++; if (r_shifts !== 4) begin n_bad++; $display("FAIL abort_shifts actual=%0d required=4", r_shifts); end
      n_cmp++;
      if ({in_ready[2], head[2], cen[2], busy[2], done[2], error[2], err_count[2]} !== 22'd0) begin
         n_bad++;
         $display("FAIL abort_outputs actual=%b required=0",
                  {in_ready[2], head[2], cen[2], busy[2], done[2], error[2], err_count[2]});
      end
      rst = 1'b0;
      @(negedge clk);
      run(2, 1'b0, -1, 0, -1, -1, -1, 5);
      n_cmp++; if (r_shifts !== 16) begin n_bad++; $display("FAIL restart_shifts actual=%0d required=16", r_shifts); end
      n_cmp++; if (r_gaps !== 0) begin n_bad++; $display("FAIL restart_gaps actual=%0d required=0", r_gaps); end
      n_cmp++; if (r_done !== 18) begin n_bad++; $display("FAIL restart_done_cycle actual=%0d required=18", r_done); end
      n_cmp++; if (ch16 !== 16'h1234) begin n_bad++; $display("FAIL restart_chain actual=%h required=1234", ch16); end
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start[i] = 1'b0; verify[i] = 1'b0; in_valid[i] = 1'b0;
         in_data[i] = 8'h00; flip[i] = 1'b0;
      end
      test_reset();
      test_single_byte();
      test_verify_clean();
      test_verify_faults();
      test_partial_byte();
      test_stall();
      test_reset_and_restart();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
